// File: rtl/rx_frame_assembler_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_pkg
// Shared definitions for the receive frame assembler:
//   - FSM state encodings (S_OPCODE, S_OPERAND, S_CHECK)
//   - error codes reported on error_code (ERR_NONE/ERR_CSUM/ERR_TIMEOUT/ERR_OVERRUN)
//   - operand_width(): bits per operand for a given byte count
//   - count_width():   register width for a counter of max_count states,
//                      never less than one bit
// -----------------------------------------------------------------------------
package rx_frame_pkg;

    localparam logic [1:0] S_OPCODE  = 2'd0;
    localparam logic [1:0] S_OPERAND = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    function automatic int operand_width(input int operand_bytes);
        return 8 * operand_bytes;
    endfunction

    function automatic int count_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/rx_frame_assembler_if.sv
// -----------------------------------------------------------------------------
// rx_frame_assembler_if
// Bundles the byte input stream and the frame output handshake.
//   rx_data_ready / rx_data      : byte strobe and byte from the UART receiver
//   frame_valid / frame_ready    : output frame handshake
//   frame_opcode / frame_operands: held frame contents
//   frame_error / error_code     : discard pulse and last error code
//   busy                         : a frame is partially received
// Modports:
//   master : the assembler (consumes bytes, produces frames)
//   slave  : the environment (byte source and frame consumer)
// -----------------------------------------------------------------------------
interface rx_frame_assembler_if #(
    parameter int OPERANDS      = 2,
    parameter int OPERAND_BYTES = 1
);
    localparam int OW = rx_frame_pkg::operand_width(OPERAND_BYTES);

    logic                     rx_data_ready;
    logic [7:0]               rx_data;
    logic                     frame_valid;
    logic                     frame_ready;
    logic [7:0]               frame_opcode;
    logic [OPERANDS*OW-1:0]   frame_operands;
    logic                     frame_error;
    logic [1:0]               error_code;
    logic                     busy;

    modport master (
        input  rx_data_ready,
        input  rx_data,
        input  frame_ready,
        output frame_valid,
        output frame_opcode,
        output frame_operands,
        output frame_error,
        output error_code,
        output busy
    );

    modport slave (
        output rx_data_ready,
        output rx_data,
        output frame_ready,
        input  frame_valid,
        input  frame_opcode,
        input  frame_operands,
        input  frame_error,
        input  error_code,
        input  busy
    );

endinterface

// File: rtl/rx_idle_timer.sv
// -----------------------------------------------------------------------------
// rx_idle_timer
// Counts idle clocks between bytes of a frame.
//   clock   : system clock
//   reset   : synchronous, active-low reset
//   clear   : zero the count this cycle (byte seen or timeout taken)
//   enable  : count only while asserted (frame in progress); otherwise held at 0
//   expire  : count has reached TIMEOUT_CYCLES-1 while enabled
// The count saturates at TIMEOUT_CYCLES-1 so it can never wrap back to a
// value that would hide an expiry. TIMEOUT_CYCLES=0 removes the timer and
// ties expire low.
// -----------------------------------------------------------------------------
module rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset, clear, enable};
            assign expire        = 1'b0;
        end else begin : g_on
            localparam int TW = rx_frame_pkg::count_width(TIMEOUT_CYCLES);
            localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

            logic [TW-1:0] count_reg;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    count_reg <= '0;
                end else if (clear || !enable) begin
                    count_reg <= '0;
                end else if (count_reg != LAST) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign expire = enable && (count_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/rx_frame_assembler.sv
// -----------------------------------------------------------------------------
// rx_frame_assembler
// Assembles opcode + OPERANDS operands (OPERAND_BYTES each, little-endian,
// operand 0 first) + optional XOR checksum byte from a byte strobe stream,
// and presents the finished frame on a valid/ready handshake.
//   clock  : system clock
//   reset  : synchronous, active-low reset
//   bus    : rx_frame_assembler_if.master (byte input, frame output, errors)
// Frames are collected in shadow registers and copied to the output registers
// on completion, so reception continues while a frame is held. A frame that
// completes while the held one has not been accepted is dropped (overrun).
// Checksum mismatch, idle timeout and overrun give a one-cycle frame_error
// pulse with error_code updated in the same cycle; held outputs are untouched.
// -----------------------------------------------------------------------------
module rx_frame_assembler
    import rx_frame_pkg::*;
#(
    parameter int OPERANDS       = 2,
    parameter int OPERAND_BYTES  = 1,
    parameter int CHECKSUM_EN    = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset,
    rx_frame_assembler_if.master bus
);

    localparam int OW     = operand_width(OPERAND_BYTES);
    localparam int FW     = OPERANDS * OW;
    localparam int NBYTES = OPERANDS * OPERAND_BYTES;
    localparam int BYTE_W = count_width(OPERAND_BYTES);
    localparam int OPND_W = count_width(OPERANDS);

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(OPERAND_BYTES - 1);
    localparam logic [OPND_W-1:0] OPND_LAST = OPND_W'(OPERANDS - 1);

    logic              strobe;
    logic [7:0]        data;

    logic [1:0]        state_reg, state_next;
    logic [BYTE_W-1:0] byte_idx_reg, byte_idx_next;
    logic [OPND_W-1:0] opnd_idx_reg, opnd_idx_next;
    logic [7:0]        csum_reg, csum_next;

    logic [7:0]        shadow_opcode_reg;
    logic [FW-1:0]     shadow_operands_reg;
    logic [FW-1:0]     shadow_operands_next;

    logic              valid_reg;
    logic [7:0]        out_opcode_reg;
    logic [FW-1:0]     out_operands_reg;
    logic              frame_error_reg;
    logic [1:0]        error_code_reg;

    logic              busy;
    logic              timer_expire;
    logic              timeout_hit;
    logic              last_byte;
    logic              complete;
    logic              csum_bad;
    logic              overrun;
    logic              load_output;
    logic              err_any;
    logic [1:0]        err_code;

    assign strobe = bus.rx_data_ready;
    assign data   = bus.rx_data;
    assign busy   = (state_reg != S_OPCODE);

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout_hit = timer_expire && !strobe;

    rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clock (clock),
        .reset (reset),
        .clear (strobe || timeout_hit),
        .enable(busy),
        .expire(timer_expire)
    );

    assign last_byte = (byte_idx_reg == BYTE_LAST) && (opnd_idx_reg == OPND_LAST);

    // Per-byte-lane write enables into the operand shadow. The next-value
    // view lets a no-checksum frame complete on its final operand byte.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            localparam int LANE_OPND = gi / OPERAND_BYTES;
            localparam int LANE_BYTE = gi % OPERAND_BYTES;
            logic lane_we;
            assign lane_we = strobe && (state_reg == S_OPERAND)
                          && (opnd_idx_reg == OPND_W'(LANE_OPND))
                          && (byte_idx_reg == BYTE_W'(LANE_BYTE));
            assign shadow_operands_next[gi*8 +: 8] =
                lane_we ? data : shadow_operands_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        opnd_idx_next = opnd_idx_reg;
        csum_next     = csum_reg;
        complete      = 1'b0;
        csum_bad      = 1'b0;
        if (timeout_hit) begin
            state_next    = S_OPCODE;
            byte_idx_next = '0;
            opnd_idx_next = '0;
        end else if (strobe) begin
            case (state_reg)
                S_OPCODE: begin
                    csum_next     = data;
                    state_next    = S_OPERAND;
                    byte_idx_next = '0;
                    opnd_idx_next = '0;
                end
                S_OPERAND: begin
                    csum_next = csum_reg ^ data;
                    if (last_byte) begin
                        byte_idx_next = '0;
                        opnd_idx_next = '0;
                        if (CHECKSUM_EN != 0) begin
                            state_next = S_CHECK;
                        end else begin
                            state_next = S_OPCODE;
                            complete   = 1'b1;
                        end
                    end else if (byte_idx_reg == BYTE_LAST) begin
                        byte_idx_next = '0;
                        opnd_idx_next = opnd_idx_reg + 1'b1;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                    end
                end
                S_CHECK: begin
                    state_next = S_OPCODE;
                    if (data == csum_reg) begin
                        complete = 1'b1;
                    end else begin
                        csum_bad = 1'b1;
                    end
                end
                default: begin
                    state_next = S_OPCODE;
                end
            endcase
        end
    end

    // Output register may take a new frame when empty or being accepted now.
    assign load_output = complete && (!valid_reg || bus.frame_ready);
    assign overrun     = complete && valid_reg && !bus.frame_ready;
    assign err_any     = csum_bad || timeout_hit || overrun;

    always_comb begin
        err_code = ERR_NONE;
        if (csum_bad) begin
            err_code = ERR_CSUM;
        end else if (timeout_hit) begin
            err_code = ERR_TIMEOUT;
        end else if (overrun) begin
            err_code = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg           <= S_OPCODE;
            byte_idx_reg        <= '0;
            opnd_idx_reg        <= '0;
            csum_reg            <= '0;
            shadow_opcode_reg   <= '0;
            shadow_operands_reg <= '0;
            valid_reg           <= 1'b0;
            out_opcode_reg      <= '0;
            out_operands_reg    <= '0;
            frame_error_reg     <= 1'b0;
            error_code_reg      <= ERR_NONE;
        end else begin
            state_reg           <= state_next;
            byte_idx_reg        <= byte_idx_next;
            opnd_idx_reg        <= opnd_idx_next;
            csum_reg            <= csum_next;
            shadow_operands_reg <= shadow_operands_next;
            if (strobe && (state_reg == S_OPCODE)) begin
                shadow_opcode_reg <= data;
            end

            if (load_output) begin
                valid_reg        <= 1'b1;
                out_opcode_reg   <= shadow_opcode_reg;
                out_operands_reg <= shadow_operands_next;
            end else if (valid_reg && bus.frame_ready) begin
                valid_reg <= 1'b0;
            end

            frame_error_reg <= err_any;
            if (err_any) begin
                error_code_reg <= err_code;
            end
        end
    end

    assign bus.frame_valid    = valid_reg;
    assign bus.frame_opcode   = out_opcode_reg;
    assign bus.frame_operands = out_operands_reg;
    assign bus.frame_error    = frame_error_reg;
    assign bus.error_code     = error_code_reg;
    assign bus.busy           = busy;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_assembler
// Directed bench for rx_frame_assembler with OPERANDS=2, OPERAND_BYTES=2,
// CHECKSUM_EN=1, TIMEOUT_CYCLES=16. Inputs change and outputs are sampled on
// the falling clock edge; the design samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_rx_frame_assembler;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    rx_frame_assembler_if #(.OPERANDS(2), .OPERAND_BYTES(2)) bus ();

    rx_frame_assembler #(
        .OPERANDS      (2),
        .OPERAND_BYTES (2),
        .CHECKSUM_EN   (1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // opcode, op0 lo, op0 hi, op1 lo, op1 hi, checksum
    localparam logic [47:0] FRAME_A     = 48'h01_34_12_78_56_09;
    localparam logic [47:0] FRAME_A_BAD = 48'h01_34_12_78_56_00;
    localparam logic [47:0] FRAME_B     = 48'h02_AA_BB_CC_DD_02;
    localparam logic [31:0] OPS_A       = 32'h5678_1234;
    localparam logic [31:0] OPS_B       = 32'hDDCC_BBAA;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
        $display("[TB] check %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Called at a falling edge; strobe is seen by the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_ready = 1'b1;
        @(negedge clock);
        bus.rx_data_ready = 1'b0;
    endtask

    // Sends the first n bytes of a frame, most significant byte first.
    task automatic send_bytes(input logic [47:0] frame, input int n);
        logic [47:0] f;
        f = frame;
        for (int i = 0; i < n; i++) begin
            send_byte(f[47:40]);
            f = f << 8;
        end
    endtask

    initial begin
        bus.rx_data_ready = 1'b0;
        bus.rx_data       = 8'h00;
        bus.frame_ready   = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_valid",    64'(bus.frame_valid),    64'd0);
        check("reset_opcode",   64'(bus.frame_opcode),   64'd0);
        check("reset_operands", 64'(bus.frame_operands), 64'd0);
        check("reset_error",    64'(bus.frame_error),    64'd0);
        check("reset_code",     64'(bus.error_code),     64'd0);
        check("reset_busy",     64'(bus.busy),           64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Good frame with consumer ready
        bus.frame_ready = 1'b1;
        send_bytes(FRAME_A, 5);
        check("good_busy_mid",   64'(bus.busy),           64'd1);
        check("good_valid_pre",  64'(bus.frame_valid),    64'd0);
        send_byte(8'h09);
        check("good_valid",      64'(bus.frame_valid),    64'd1);
        check("good_opcode",     64'(bus.frame_opcode),   64'h01);
        check("good_operands",   64'(bus.frame_operands), 64'(OPS_A));
        check("good_error",      64'(bus.frame_error),    64'd0);
        check("good_code",       64'(bus.error_code),     64'd0);
        check("good_busy_after", 64'(bus.busy),           64'd0);
        @(negedge clock);
        check("good_accepted",   64'(bus.frame_valid),    64'd0);

        // Bad checksum
        send_bytes(FRAME_A_BAD, 6);
        check("csum_error",      64'(bus.frame_error),    64'd1);
        check("csum_code",       64'(bus.error_code),     64'd1);
        check("csum_valid",      64'(bus.frame_valid),    64'd0);
        @(negedge clock);
        check("csum_pulse_end",  64'(bus.frame_error),    64'd0);
        check("csum_code_hold",  64'(bus.error_code),     64'd1);
        send_bytes(FRAME_B, 6);
        check("csum_next_valid", 64'(bus.frame_valid),    64'd1);
        check("csum_next_ops",   64'(bus.frame_operands), 64'(OPS_B));
        @(negedge clock);

        // Timeout: error appears 16 cycles after the last strobe
        send_bytes(FRAME_A, 2);
        repeat (15) @(negedge clock);
        check("tmo_not_yet",     64'(bus.frame_error),    64'd0);
        check("tmo_busy_before", 64'(bus.busy),           64'd1);
        @(negedge clock);
        check("tmo_error",       64'(bus.frame_error),    64'd1);
        check("tmo_code",        64'(bus.error_code),     64'd2);
        check("tmo_busy_after",  64'(bus.busy),           64'd0);
        check("tmo_valid",       64'(bus.frame_valid),    64'd0);
        repeat (4) @(negedge clock);
        check("tmo_pulse_end",   64'(bus.frame_error),    64'd0);
        send_bytes(FRAME_A, 6);
        check("tmo_next_valid",  64'(bus.frame_valid),    64'd1);
        check("tmo_next_ops",    64'(bus.frame_operands), 64'(OPS_A));
        @(negedge clock);

        // Strobe in the expiry cycle wins
        send_bytes(FRAME_B, 2);
        repeat (15) @(negedge clock);
        send_byte(8'hBB);
        check("edge_no_error",   64'(bus.frame_error),    64'd0);
        check("edge_busy",       64'(bus.busy),           64'd1);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'h02);
        check("edge_valid",      64'(bus.frame_valid),    64'd1);
        check("edge_opcode",     64'(bus.frame_opcode),   64'h02);
        check("edge_ops",        64'(bus.frame_operands), 64'(OPS_B));
        check("edge_code",       64'(bus.error_code),     64'd2);
        @(negedge clock);

        // Backpressure and overrun
        bus.frame_ready = 1'b0;
        send_bytes(FRAME_A, 6);
        check("bp_first_valid",  64'(bus.frame_valid),    64'd1);
        send_bytes(FRAME_B, 6);
        check("ovr_error",       64'(bus.frame_error),    64'd1);
        check("ovr_code",        64'(bus.error_code),     64'd3);
        check("ovr_valid_held",  64'(bus.frame_valid),    64'd1);
        check("ovr_opcode_held", 64'(bus.frame_opcode),   64'h01);
        check("ovr_ops_held",    64'(bus.frame_operands), 64'(OPS_A));
        @(negedge clock);
        check("ovr_pulse_end",   64'(bus.frame_error),    64'd0);
        bus.frame_ready = 1'b1;
        @(negedge clock);
        check("ovr_accepted",    64'(bus.frame_valid),    64'd0);
        bus.frame_ready = 1'b0;

        // Accept in the same cycle a new frame completes
        send_bytes(FRAME_A, 6);
        check("col_first_valid", 64'(bus.frame_valid),    64'd1);
        send_bytes(FRAME_B, 5);
        bus.rx_data       = 8'h02;
        bus.rx_data_ready = 1'b1;
        bus.frame_ready   = 1'b1;
        @(negedge clock);
        bus.rx_data_ready = 1'b0;
        bus.frame_ready   = 1'b0;
        check("col_valid",       64'(bus.frame_valid),    64'd1);
        check("col_opcode",      64'(bus.frame_opcode),   64'h02);
        check("col_ops",         64'(bus.frame_operands), 64'(OPS_B));
        check("col_no_error",    64'(bus.frame_error),    64'd0);
        @(negedge clock);
        check("col_held",        64'(bus.frame_valid),    64'd1);
        bus.frame_ready = 1'b1;
        @(negedge clock);
        check("col_accepted",    64'(bus.frame_valid),    64'd0);
        bus.frame_ready = 1'b0;

        // Reset in the middle of a frame while an output is held
        send_bytes(FRAME_A, 6);
        check("rst_held_valid",  64'(bus.frame_valid),    64'd1);
        send_bytes(FRAME_B, 3);
        check("rst_busy_pre",    64'(bus.busy),           64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid",       64'(bus.frame_valid),    64'd0);
        check("rst_opcode",      64'(bus.frame_opcode),   64'd0);
        check("rst_operands",    64'(bus.frame_operands), 64'd0);
        check("rst_error",       64'(bus.frame_error),    64'd0);
        check("rst_code",        64'(bus.error_code),     64'd0);
        check("rst_busy",        64'(bus.busy),           64'd0);
        reset = 1'b1;
        bus.frame_ready = 1'b1;
        @(negedge clock);
        send_bytes(FRAME_B, 6);
        check("rst_next_valid",  64'(bus.frame_valid),    64'd1);
        check("rst_next_opcode", 64'(bus.frame_opcode),   64'h02);
        check("rst_next_ops",    64'(bus.frame_operands), 64'(OPS_B));
        check("rst_next_error",  64'(bus.frame_error),    64'd0);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
